// File: rtl/light_ctrl_pkg.sv
// Shared types and AXI4 encodings for the light burst controllers.
package light_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    localparam logic [1:0] INCR    = 2'b01;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

endpackage

// File: rtl/light_rr_arbiter.sv
// Two-requester round-robin grant: the requester not served last wins a tie.
module light_rr_arbiter (
    input  logic [1:0] req_i,
    input  logic       last_served_i,
    output logic [1:0] grant_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_idx_o = 1'b0;
        grant_o     = 2'b00;
        if (req_i == 2'b11) begin
            grant_idx_o = ~last_served_i;
        end else begin
            grant_idx_o = req_i[1];
        end
        if (|req_i) begin
            grant_o = grant_idx_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/light_burst_arbiter.sv
// Arbitrates two burst requesters onto one AXI4 write master, one burst in flight.
module light_burst_arbiter
    import light_ctrl_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_BURST_LEN        = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [1:0]                        req_valid,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
    output logic [1:0]                        req_ready,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   wd_data,
    input  logic [1:0]                        wd_valid,
    output logic [1:0]                        wd_ready,
    output logic [1:0]                        done,
    output logic [1:0]                        done_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic                              busy
);

    localparam int unsigned AW   = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
    localparam int unsigned CntW = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(C_BURST_LEN - 1);

    state_e          state_q;
    logic            grant_q;
    logic            last_served_q;
    logic            aw_valid_q;
    logic [CntW-1:0] beat_cnt_q;
    logic [AW-1:0]   aw_addr_q;
    logic [1:0]      req_ready_q;

    logic [1:0]      arb_grant;
    logic            arb_idx;
    logic            in_data;
    logic            in_resp;
    logic            w_last;
    logic            w_hs;
    logic            b_hs;
    logic [1:0]      grant_1h;

    light_rr_arbiter u_rr (
        .req_i         (req_valid),
        .last_served_i (last_served_q),
        .grant_o       (arb_grant),
        .grant_idx_o   (arb_idx)
    );

    assign in_data  = (state_q == StData);
    assign in_resp  = (state_q == StResp);
    assign grant_1h = grant_q ? 2'b10 : 2'b01;
    assign w_last   = in_data && (beat_cnt_q == LastBeat);
    assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs     = in_resp && M_AXI_BVALID;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            aw_valid_q    <= 1'b0;
            beat_cnt_q    <= '0;
            aw_addr_q     <= '0;
            req_ready_q   <= 2'b00;
        end else begin
            req_ready_q <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        grant_q     <= arb_idx;
                        req_ready_q <= arb_grant;
                        aw_addr_q   <= arb_idx ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                        aw_valid_q  <= 1'b1;
                        beat_cnt_q  <= '0;
                        state_q     <= StAddr;
                    end
                end
                StAddr: begin
                    // AWVALID is high for the whole of this state, so AWREADY alone completes it
                    if (M_AXI_AWREADY) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (w_last) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (M_AXI_BVALID) begin
                        last_served_q <= grant_q;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = (state_q != StIdle);

    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWLEN   = 8'(C_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = SIZE_4B;
    assign M_AXI_AWBURST = INCR;
    assign M_AXI_AWVALID = aw_valid_q;

    // W channel is a straight pass-through of the granted requester while in DATA
    assign M_AXI_WVALID  = in_data && (grant_q ? wd_valid[1] : wd_valid[0]);
    assign M_AXI_WDATA   = in_data ? (grant_q ? wd_data[2*DW-1:DW] : wd_data[DW-1:0]) : '0;
    assign M_AXI_WSTRB   = in_data ? '1 : '0;
    assign M_AXI_WLAST   = w_last;
    assign wd_ready      = (in_data && M_AXI_WREADY) ? grant_1h : 2'b00;

    assign M_AXI_BREADY  = in_resp;
    assign done          = b_hs ? grant_1h : 2'b00;
    assign done_resp     = b_hs ? M_AXI_BRESP : OKAY;

endmodule

// File: tb/tb_light_burst_arbiter.sv
// Randomised bench for light_burst_arbiter: AXI slave and requester models plus a
// transaction-level reference that predicts grants, addresses, beats and responses.
module tb_light_burst_arbiter;

    localparam int AW = 6;

    logic        ACLK;
    logic        ARESETN;
    logic [1:0]  req_valid;
    logic [11:0] req_addr;
    logic [1:0]  req_ready;
    logic [63:0] wd_data;
    logic [1:0]  wd_valid;
    logic [1:0]  wd_ready;
    logic [1:0]  done;
    logic [1:0]  done_resp;
    logic [5:0]  M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic        busy;

    light_burst_arbiter #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BURST_LEN        (8)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .wd_data       (wd_data),
        .wd_valid      (wd_valid),
        .wd_ready      (wd_ready),
        .done          (done),
        .done_resp     (done_resp),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .busy          (busy)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int beats = 0;
    int aw_stall = 0;

    // Stimulus knobs and per-requester queues
    int          aw_delay = 0;
    int          wr_mode = 0;
    bit          gap = 1'b0;
    logic [1:0]  bresp_val = 2'b00;
    logic [5:0]  rq [2][$];
    logic [31:0] wq [2][$];
    logic [31:0] exp_w [2][$];
    int          done_log [$];
    logic [31:0] mem [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] out_vec();
        return {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, req_ready, wd_ready,
                done, done_resp, busy, M_AXI_AWADDR};
    endfunction

    task automatic push_req(input int r, input logic [5:0] a, input logic [31:0] base,
                            input bit seq);
        logic [31:0] d;
        rq[r].push_back(a);
        for (int k = 0; k < 8; k++) begin
            d = seq ? base + 32'(k) : $urandom;
            wq[r].push_back(d);
            exp_w[r].push_back(d);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge ACLK);
            n++;
        end
        check("done_timeout", 64'(done_cnt >= target), 64'(1));
    endtask

    function automatic logic [5:0] rand_addr();
        return 6'($urandom_range(0, 15) << 2);
    endfunction

    // Requester model: presents request heads and beat data, pops on handshake
    initial begin
        logic [1:0]  whs;
        logic [31:0] tmp;
        req_valid = '0;
        req_addr  = '0;
        wd_valid  = '0;
        wd_data   = '0;
        forever begin
            @(negedge ACLK);
            whs = wd_valid & wd_ready;
            @(posedge ACLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (whs[i] && wq[i].size() > 0) tmp = wq[i].pop_front();
                req_valid[i] = ARESETN && (rq[i].size() > 0);
                if (rq[i].size() > 0) req_addr[i*AW +: AW] = rq[i][0];
                if (wq[i].size() > 0 && (!gap || $urandom_range(0, 2) != 0)) begin
                    wd_valid[i]          = 1'b1;
                    wd_data[i*32 +: 32]  = wq[i][0];
                end else begin
                    wd_valid[i]          = 1'b0;
                    wd_data[i*32 +: 32]  = $urandom;
                end
            end
        end
    end

    // AXI slave model
    initial begin
        bit bhs;
        int aw_wait = 0;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        forever begin
            @(negedge ACLK);
            bhs = M_AXI_BVALID && M_AXI_BREADY;
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                M_AXI_AWREADY = 1'b0;
                M_AXI_WREADY  = 1'b0;
                M_AXI_BVALID  = 1'b0;
                aw_wait       = 0;
            end else begin
                if (M_AXI_AWVALID) begin
                    M_AXI_AWREADY = (aw_wait >= aw_delay);
                    aw_wait++;
                end else begin
                    M_AXI_AWREADY = 1'b0;
                    aw_wait       = 0;
                end
                case (wr_mode)
                    0:       M_AXI_WREADY = 1'b1;
                    1:       M_AXI_WREADY = !M_AXI_WREADY;
                    default: M_AXI_WREADY = 1'($urandom_range(0, 1));
                endcase
                if (bhs) M_AXI_BVALID = 1'b0;
                else if (M_AXI_BREADY && !M_AXI_BVALID && $urandom_range(0, 1) == 1)
                    M_AXI_BVALID = 1'b1;
                M_AXI_BRESP = bresp_val;
            end
        end
    end

    // Reference model: round-robin grant prediction and per-burst transaction checks
    initial begin
        int          cur = 0;
        int          m_last = 1;
        int          ei;
        bit          in_burst = 1'b0;
        bit          aw_done = 1'b0;
        logic [1:0]  prev_rv = 2'b00;
        logic [1:0]  cur_1h;
        logic [5:0]  exp_addr = '0;
        logic [31:0] ed;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                m_last   = 1;
                in_burst = 1'b0;
                aw_done  = 1'b0;
                beats    = 0;
                prev_rv  = 2'b00;
            end else begin
                if (|req_ready) begin
                    ei = (prev_rv == 2'b11) ? (1 - m_last) : (prev_rv[1] ? 1 : 0);
                    check("grant", 64'(req_ready), 64'(2'b01 << ei));
                    check("grant_while_idle", 64'(in_burst), 64'(0));
                    check("aw_latency", 64'(M_AXI_AWVALID), 64'(1));
                    check("req_pending", 64'(rq[ei].size() > 0), 64'(1));
                    if (rq[ei].size() > 0) exp_addr = rq[ei].pop_front();
                    cur      = ei;
                    in_burst = 1'b1;
                    aw_done  = 1'b0;
                    beats    = 0;
                end
                cur_1h = (cur == 1) ? 2'b10 : 2'b01;
                if (M_AXI_AWVALID) begin
                    check("aw_one_outstanding", 64'({in_burst, aw_done}), 64'(2'b10));
                    check("aw_fields", 64'({M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST}),
                          64'({exp_addr, 8'd7, 3'b010, 2'b01}));
                    if (M_AXI_AWREADY) aw_done = 1'b1;
                    else aw_stall++;
                end
                if (|wd_ready) check("wd_ready_sel", 64'(wd_ready), 64'(cur_1h));
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    check("w_after_aw", 64'(aw_done), 64'(1));
                    ed = (exp_w[cur].size() > 0) ? exp_w[cur].pop_front() : 32'hDEAD_BEEF;
                    check("w_data", 64'(M_AXI_WDATA), 64'(ed));
                    check("w_last", 64'(M_AXI_WLAST), 64'(beats == 7));
                    check("w_strb", 64'(M_AXI_WSTRB), 64'(4'hF));
                    mem[(int'(exp_addr[5:2]) + beats) & 15] = M_AXI_WDATA;
                    beats++;
                end
                if (|done) begin
                    check("done_sel", 64'({in_burst, done}), 64'({1'b1, cur_1h}));
                    check("done_beats", 64'(beats), 64'(8));
                    check("done_resp", 64'(done_resp), 64'(bresp_val));
                    check("done_bready", 64'(M_AXI_BREADY), 64'(1));
                    m_last = cur;
                    done_cnt++;
                    done_log.push_back(cur);
                    in_burst = 1'b0;
                    aw_done  = 1'b0;
                    beats    = 0;
                end
                prev_rv = req_valid;
            end
        end
    end

    task automatic do_reset();
        @(posedge ACLK);
        #2 ARESETN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            wq[i].delete();
            exp_w[i].delete();
        end
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
    endtask

    initial begin
        int          base;
        int          mask;
        int          nreq;
        ARESETN = 1'b0;

        // Reset state
        repeat (2) @(posedge ACLK);
        #2;
        check("reset_outputs", 64'(out_vec()), 64'(0));
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("idle_busy", 64'(busy), 64'(0));

        // Single requester 0, sequential data, memory readback
        for (int k = 0; k < 16; k++) mem[k] = '0;
        push_req(0, 6'h00, 32'd1, 1'b1);
        wait_done(1, 200);
        for (int k = 0; k < 8; k++) check("mem_readback", 64'(mem[k]), 64'(k + 1));

        // Both requesters from reset: strict alternation starting with 0
        do_reset();
        done_log.delete();
        base = done_cnt;
        push_req(0, rand_addr(), 32'h1000, 1'b1);
        push_req(1, rand_addr(), 32'h2000, 1'b1);
        push_req(0, rand_addr(), 32'h3000, 1'b1);
        push_req(1, rand_addr(), 32'h4000, 1'b1);
        wait_done(base + 4, 600);
        check("rr_count", 64'(done_log.size()), 64'(4));
        for (int k = 0; k < 4; k++)
            check("rr_order", 64'((k < done_log.size()) ? done_log[k] : -1), 64'(k % 2));

        // Toggling WREADY with gapped wd_valid
        wr_mode = 1;
        gap     = 1'b1;
        push_req(1, 6'h10, 32'hA0, 1'b1);
        wait_done(done_cnt + 1, 400);
        check("no_beat_lost", 64'(exp_w[1].size() + wq[1].size()), 64'(0));
        wr_mode = 0;
        gap     = 1'b0;

        // Error response passes through, FSM returns to idle
        bresp_val = 2'b10;
        push_req(0, rand_addr(), 32'h0, 1'b0);
        wait_done(done_cnt + 1, 200);
        @(negedge ACLK);
        check("idle_after_slverr", 64'(busy), 64'(0));
        bresp_val = 2'b00;

        // Reset after beat 4 abandons the burst
        push_req(0, 6'h24, 32'h500, 1'b1);
        for (int n = 0; n < 200 && beats < 4; n++) @(posedge ACLK);
        check("reached_beat4", 64'(beats >= 4), 64'(1));
        #2 ARESETN = 1'b0;
        #1 check("midburst_reset_outputs", 64'(out_vec()), 64'(0));
        for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            wq[i].delete();
            exp_w[i].delete();
        end
        base = done_cnt;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (6) @(posedge ACLK);
        check("no_done_after_reset", 64'(done_cnt), 64'(base));
        push_req(1, 6'h08, 32'h0, 1'b0);
        wait_done(base + 1, 200);

        // AWREADY held low for 10 cycles
        aw_delay = 10;
        aw_stall = 0;
        push_req(1, rand_addr(), 32'h0, 1'b0);
        wait_done(done_cnt + 1, 300);
        check("aw_stall_cycles", 64'(aw_stall), 64'(10));
        aw_delay = 0;

        // Randomised traffic
        for (int it = 0; it < 10; it++) begin
            aw_delay  = $urandom_range(0, 3);
            wr_mode   = $urandom_range(0, 2);
            gap       = 1'($urandom_range(0, 1));
            bresp_val = 2'($urandom_range(0, 3));
            mask      = $urandom_range(1, 3);
            nreq      = 0;
            base      = done_cnt;
            for (int r = 0; r < 2; r++) begin
                if (mask[r]) begin
                    push_req(r, rand_addr(), 32'h0, 1'b0);
                    nreq++;
                end
            end
            wait_done(base + nreq, 600);
        end
        check("all_drained", 64'(exp_w[0].size() + exp_w[1].size() + rq[0].size() + rq[1].size()),
              64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_burst_arbiter.md
LIGHT_BURST_ARBITER -- requirements
Module: light_burst_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 6, AXI byte-address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have parameter C_BURST_LEN, default 8, beats per burst (AWLEN = C_BURST_LEN-1).
REQ-004 SHALL have ports, one per line:
 ACLK  in  1  single clock, all logic on rising edge
 ARESETN  in  1  asynchronous active-low reset
 req_valid  in  2  per-requester burst request (bit i = requester i)
 req_addr  in  2*C_M_AXI_ADDR_WIDTH  per-requester burst start address, slice i
 req_ready  out  2  request accepted (one-cycle pulse, granted requester only)
 wd_data  in  2*32  per-requester write beat data, slice i
 wd_valid  in  2  per-requester beat valid
 wd_ready  out  2  beat consumed; only the granted bit can be 1
 done  out  2  one-cycle pulse at B handshake for the granted requester
 done_resp  out  2  BRESP captured with done
 M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  C_M_AXI_ADDR_WIDTH/8/3/2/1  AXI4 write address
 M_AXI_AWREADY  in  1
 M_AXI_WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  AXI4 write data
 M_AXI_WREADY  in  1
 M_AXI_BRESP/BVALID  in  2/1
 M_AXI_BREADY  out  1
 busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA, RESP.
REQ-006 IDLE: if any req_valid, SHALL grant round-robin (requester not granted last has priority; after reset requester 0 has priority), pulse req_ready[grant], latch addr, go ADDR next cycle.
REQ-007 ADDR: AWVALID=1 with AWADDR=latched addr, AWLEN=C_BURST_LEN-1, AWSIZE=3'b010, AWBURST=2'b01; on AWVALID&&AWREADY go DATA.
REQ-008 AWVALID, once asserted, SHALL remain asserted with stable fields until AWREADY.
REQ-009 DATA: WVALID = wd_valid[grant]; WDATA = wd_data[grant]; wd_ready[grant] = WREADY; WSTRB=4'hF.
REQ-010 Beat counter (width clog2(C_BURST_LEN)) SHALL increment on each WVALID&&WREADY; WLAST=1 when count == C_BURST_LEN-1; the WLAST handshake goes RESP.
REQ-011 RESP: BREADY=1; on BVALID pulse done[grant], drive done_resp[grant]=BRESP for that cycle, record grant as last-served, go IDLE.
REQ-012 No AW issued before the previous B is received (one outstanding burst).
REQ-013 Simultaneous req_valid=2'b11 in IDLE SHALL serve both in alternation; a requester dropping req_valid before grant is not served.
REQ-014 req_valid or req_addr changes after grant SHALL not affect the burst in flight.
REQ-015 Requester stalling wd_valid SHALL stall W with no beat lost or duplicated; no timeout.
REQ-016 BRESP other than OKAY SHALL be passed through on done_resp only; no retry.
REQ-017 IDLE to first AWVALID latency SHALL be 1 cycle after grant cycle.

Reset
REQ-018 ARESETN low SHALL asynchronously force IDLE, beat count 0, last-served=1, and all outputs 0 (AWVALID, WVALID, WLAST, BREADY, req_ready, wd_ready, done, done_resp, busy, AWADDR).
REQ-019 Reset mid-burst SHALL abandon the burst; no done pulse follows reset release.

Structure
REQ-020 A shared package light_ctrl_pkg SHALL hold the FSM state enum, AXI burst/size/resp constants (INCR, SIZE_4B, OKAY, SLVERR).
REQ-021 Round-robin grant logic SHALL be a sub-module light_rr_arbiter (2 requesters, last-served input, grant output).

Verification
REQ-022 Single requester 0, addr 0x00, data 1..8, ready always high -> AW at addr 0/len 7, 8 beats, WLAST on beat 8, done[0] with resp 0; memory readback 1..8.
REQ-023 Both requesters asserted simultaneously after reset -> order 0,1,0,1 over four bursts; no W overlap.
REQ-024 WREADY toggling every other cycle and wd_valid gapped -> exactly 8 beats, data order intact.
REQ-025 Slave returns BRESP=SLVERR -> done[grant]=1, done_resp=2'b10, FSM back to IDLE.
REQ-026 ARESETN low after beat 4 -> all outputs 0 at once; fresh request after release completes normally.
REQ-027 AWREADY held low 10 cycles -> AWVALID and AWADDR stable throughout; no W beat before AW handshake.
